memory_cycle: RTL

- MEM stage of the 5-stage RISC-V pipeline, directly downstream of the execute stage; consumes its EX/MEM register outputs.
- Holds the word-organised data memory and performs byte/half/word stores with lane enables.
- Performs sign/zero-extended loads.
- Registers results into the MEM/WB pipeline register feeding the writeback mux.

---
 rtl/memory_cycle.sv | 138 +++++++++++++
 1 files changed

// File: rtl/memory_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_cycle : RISC-V MEM stage - byte-lane data memory, extended    |
// |                loads, misalignment detect and MEM/WB register.       |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module memory_cycle #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_BITS   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] InstrM,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  output logic        MisalignM,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] InstrW,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW
);

  localparam logic [1:0] c_SRC_LOAD = 2'b01;
  localparam logic [2:0] c_F3_B     = 3'b000;
  localparam logic [2:0] c_F3_H     = 3'b001;
  localparam logic [2:0] c_F3_W     = 3'b010;
  localparam logic [2:0] c_F3_BU    = 3'b100;
  localparam logic [2:0] c_F3_HU    = 3'b101;

  logic [ADDR_BITS-1:0] w_wordIdx;
  logic [1:0]           w_offset;
  logic [2:0]           w_funct3;
  logic                 w_isLoad;
  logic                 w_isHalf;
  logic                 w_isWord;
  logic                 w_misalign;
  logic [3:0]           w_byteEn;
  logic [31:0]          w_wrData;
  logic [31:0]          w_rdWord;
  logic [7:0]           w_rdByte;
  logic [15:0]          w_rdHalf;
  logic [31:0]          w_extData;
  logic [31:0]          w_loadData;

  assign w_wordIdx = ALUResultM[ADDR_BITS+1:2];
  assign w_offset  = ALUResultM[1:0];
  assign w_funct3  = InstrM[14:12];
  assign w_isLoad  = (ResultSrcM == c_SRC_LOAD);

  // lhu (101) only counts as a halfword access for loads; as a store it is a no-op.
  assign w_isHalf   = (w_funct3 == c_F3_H) || ((w_funct3 == c_F3_HU) && w_isLoad);
  assign w_isWord   = (w_funct3 == c_F3_W);
  assign w_misalign = (MemWriteM || w_isLoad) &&
                      ((w_isHalf && w_offset[0]) || (w_isWord && (w_offset != 2'b00)));
  assign MisalignM  = w_misalign;

  always_comb begin
    w_byteEn = 4'b0000;
    w_wrData = WriteDataM;
    if (MemWriteM && !w_misalign) begin
      case (w_funct3)
        c_F3_B: begin
          w_byteEn = 4'b0001 << w_offset;
          w_wrData = {4{WriteDataM[7:0]}};
        end
        c_F3_H: begin
          w_byteEn = w_offset[1] ? 4'b1100 : 4'b0011;
          w_wrData = {2{WriteDataM[15:0]}};
        end
        c_F3_W:  w_byteEn = 4'b1111;
        default: w_byteEn = 4'b0000;
      endcase
    end
  end

  // One array per byte lane; reads see pre-edge contents, giving old-data on collisions.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] r_bytes [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (w_byteEn[i]) begin
        r_bytes[w_wordIdx] <= w_wrData[8*i +: 8];
      end
    end

    assign w_rdWord[8*i +: 8] = r_bytes[w_wordIdx];
  end

  always_comb begin
    case (w_offset)
      2'd0:    w_rdByte = w_rdWord[7:0];
      2'd1:    w_rdByte = w_rdWord[15:8];
      2'd2:    w_rdByte = w_rdWord[23:16];
      default: w_rdByte = w_rdWord[31:24];
    endcase
    w_rdHalf = w_offset[1] ? w_rdWord[31:16] : w_rdWord[15:0];

    case (w_funct3)
      c_F3_B:  w_extData = {{24{w_rdByte[7]}}, w_rdByte};
      c_F3_H:  w_extData = {{16{w_rdHalf[15]}}, w_rdHalf};
      c_F3_W:  w_extData = w_rdWord;
      c_F3_BU: w_extData = {24'h000000, w_rdByte};
      c_F3_HU: w_extData = {16'h0000, w_rdHalf};
      default: w_extData = 32'h0000_0000;
    endcase
    w_loadData = w_misalign ? 32'h0000_0000 : w_extData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      InstrW     <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= w_loadData;
      PCPlus4W   <= PCPlus4M;
      InstrW     <= InstrM;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM & ~(w_isLoad & w_misalign);
      ResultSrcW <= ResultSrcM;
    end
  end

endmodule
`default_nettype wire
